// File: rtl/lane_arbiter.sv
// Two-channel byte arbiter: per-channel FIFOs, SYNC idle preamble,
// then round-robin draining onto one registered output lane.
module lane_arbiter #(
   parameter int         FIFO_DEPTH  = 4,
   parameter int         SYNC_CYCLES = 4,
   parameter logic [7:0] IDLE_CHAR   = 8'hBC
) (
   input  logic       clk_2f,
   input  logic       reset,
   input  logic [7:0] data_in_0_c,
   input  logic       valid_in_0_c,
   input  logic [7:0] data_in_1_c,
   input  logic       valid_in_1_c,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       sel_out,
   output logic       full_0,
   output logic       full_1,
   output logic [3:0] drop_cnt_0,
   output logic [3:0] drop_cnt_1,
   output logic [1:0] state_out
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_SYNC   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   state_t state;
   logic [SW-1:0] sync_cnt;
   logic last_grant;

   logic [7:0] mem [2][FIFO_DEPTH];
   logic [1:0][AW-1:0] wr_ptr;
   logic [1:0][AW-1:0] rd_ptr;
   logic [1:0][CW-1:0] count;
   logic [1:0][3:0] drop_cnt;

   logic [1:0]      vld;
   logic [1:0][7:0] din;
   logic [1:0]      full;
   logic [1:0]      empty;
   logic [1:0]      push;
   logic [1:0]      drop;
   logic [1:0]      pop;
   logic            gnt_any;
   logic            gnt_ch;
   logic [7:0]      pop_data;

   assign vld = {valid_in_1_c, valid_in_0_c};
   assign din = {data_in_1_c, data_in_0_c};

   // All flags come from pre-edge counts: no same-edge bypass.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         full[c]  = (count[c] == CW'(FIFO_DEPTH));
         empty[c] = (count[c] == '0);
         push[c]  = vld[c] && !full[c] && (state != ST_RESET);
         drop[c]  = vld[c] && full[c];
      end
   end

   always_comb begin
      gnt_any = 1'b0;
      gnt_ch  = last_grant;
      if (state == ST_ACTIVE) begin
         unique case (1'b1)
            !empty[0] && !empty[1]: begin
               gnt_any = 1'b1;
               gnt_ch  = ~last_grant;
            end
            !empty[0] && empty[1]: begin
               gnt_any = 1'b1;
               gnt_ch  = 1'b0;
            end
            empty[0] && !empty[1]: begin
               gnt_any = 1'b1;
               gnt_ch  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign pop      = gnt_any ? (gnt_ch ? 2'b10 : 2'b01) : 2'b00;
   assign pop_data = mem[gnt_ch][rd_ptr[gnt_ch]];

   always_ff @(posedge clk_2f) begin
      for (int c = 0; c < 2; c++) begin
         if (push[c]) mem[c][wr_ptr[c]] <= din[c];
      end
   end

   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
            if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
            unique case ({push[c], pop[c]})
               2'b10:   count[c] <= count[c] + 1'b1;
               2'b01:   count[c] <= count[c] - 1'b1;
               default: ;
            endcase
            if (drop[c] && drop_cnt[c] != 4'hF)
               drop_cnt[c] <= drop_cnt[c] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         state      <= ST_RESET;
         sync_cnt   <= '0;
         last_grant <= 1'b1;
         data_out   <= IDLE_CHAR;
         valid_out  <= 1'b0;
         sel_out    <= 1'b0;
      end else begin
         unique case (state)
            ST_RESET: begin
               state    <= ST_SYNC;
               sync_cnt <= '0;
            end
            ST_SYNC: begin
               if (sync_cnt == SW'(SYNC_CYCLES - 1)) begin
                  state    <= ST_ACTIVE;
                  sync_cnt <= '0;
               end else begin
                  sync_cnt <= sync_cnt + 1'b1;
               end
            end
            ST_ACTIVE: ;
            default: state <= ST_RESET;
         endcase
         if (gnt_any) begin
            data_out   <= pop_data;
            valid_out  <= 1'b1;
            sel_out    <= gnt_ch;
            last_grant <= gnt_ch;
         end else begin
            data_out  <= IDLE_CHAR;
            valid_out <= 1'b0;
         end
      end
   end

   assign full_0     = full[0];
   assign full_1     = full[1];
   assign drop_cnt_0 = drop_cnt[0];
   assign drop_cnt_1 = drop_cnt[1];
   assign state_out  = state;

endmodule

// File: tb/tb_lane_arbiter.sv
// Directed-vector bench for lane_arbiter.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_lane_arbiter;

   logic       clk_2f = 1'b0;
   logic       reset;
   logic [7:0] data_in_0_c;
   logic       valid_in_0_c;
   logic [7:0] data_in_1_c;
   logic       valid_in_1_c;
   logic [7:0] data_out;
   logic       valid_out;
   logic       sel_out;
   logic       full_0;
   logic       full_1;
   logic [3:0] drop_cnt_0;
   logic [3:0] drop_cnt_1;
   logic [1:0] state_out;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] exp0 [12] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h45, 8'h47,
                             8'h49, 8'h4B, 8'h4D, 8'h4F, 8'h51, 8'h53};
   logic [7:0] exp1 [11] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h86, 8'h88,
                             8'h8A, 8'h8C, 8'h8E, 8'h90, 8'h92};

   lane_arbiter #(
      .FIFO_DEPTH (4),
      .SYNC_CYCLES(4),
      .IDLE_CHAR  (8'hBC)
   ) dut (
      .clk_2f      (clk_2f),
      .reset       (reset),
      .data_in_0_c (data_in_0_c),
      .valid_in_0_c(valid_in_0_c),
      .data_in_1_c (data_in_1_c),
      .valid_in_1_c(valid_in_1_c),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .sel_out     (sel_out),
      .full_0      (full_0),
      .full_1      (full_1),
      .drop_cnt_0  (drop_cnt_0),
      .drop_cnt_1  (drop_cnt_1),
      .state_out   (state_out)
   );

   always #5 clk_2f = ~clk_2f;

   task automatic tick();
      @(posedge clk_2f);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk8({tag, "_data"}, data_out, 8'hBC);
      chk1({tag, "_valid"}, valid_out, 1'b0);
      chk1({tag, "_sel"}, sel_out, 1'b0);
      chk1({tag, "_full0"}, full_0, 1'b0);
      chk1({tag, "_full1"}, full_1, 1'b0);
      chk4({tag, "_drop0"}, drop_cnt_0, 4'd0);
      chk4({tag, "_drop1"}, drop_cnt_1, 4'd0);
      chk2({tag, "_state"}, state_out, 2'd0);
   endtask

   initial begin
      reset        = 1'b0;
      data_in_0_c  = 8'h00;
      valid_in_0_c = 1'b0;
      data_in_1_c  = 8'h00;
      valid_in_1_c = 1'b0;
      tick();
      tick();
      chk_reset_vals("rst");

      // Sync preamble: four SYNC cycles of idle, then ACTIVE.
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk2("sync_state", state_out, 2'd1);
         chk8("sync_data", data_out, 8'hBC);
         chk1("sync_valid", valid_out, 1'b0);
      end
      tick();
      chk2("active_state", state_out, 2'd2);
      chk1("active_valid", valid_out, 1'b0);

      // Two bytes per channel on the same edges: alternating output.
      valid_in_0_c = 1'b1; data_in_0_c = 8'hFF;
      valid_in_1_c = 1'b1; data_in_1_c = 8'h00;
      tick();
      chk1("lat_valid", valid_out, 1'b0);
      data_in_0_c = 8'hEE;
      data_in_1_c = 8'h01;
      tick();
      chk8("alt0_data", data_out, 8'hFF);
      chk1("alt0_sel", sel_out, 1'b0);
      chk1("alt0_valid", valid_out, 1'b1);
      valid_in_0_c = 1'b0;
      valid_in_1_c = 1'b0;
      tick();
      chk8("alt1_data", data_out, 8'h00);
      chk1("alt1_sel", sel_out, 1'b1);
      tick();
      chk8("alt2_data", data_out, 8'hEE);
      chk1("alt2_sel", sel_out, 1'b0);
      tick();
      chk8("alt3_data", data_out, 8'h01);
      chk1("alt3_sel", sel_out, 1'b1);
      tick();
      chk8("alt_idle_data", data_out, 8'hBC);
      chk1("alt_idle_valid", valid_out, 1'b0);
      chk1("alt_idle_sel", sel_out, 1'b1);

      // Fill channel 1 during SYNC, then drain.
      reset = 1'b0;
      #1;
      chk2("rst2_state", state_out, 2'd0);
      tick();
      reset = 1'b1;
      tick();
      chk2("fill_sync", state_out, 2'd1);
      for (int k = 0; k < 4; k++) begin
         valid_in_1_c = 1'b1;
         data_in_1_c  = 8'(8'h05 + k);
         tick();
      end
      valid_in_1_c = 1'b0;
      chk2("fill_state", state_out, 2'd2);
      chk1("fill_full1", full_1, 1'b1);
      chk1("fill_full0", full_0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk8("drain_data", data_out, 8'(8'h05 + k));
         chk1("drain_sel", sel_out, 1'b1);
         chk1("drain_valid", valid_out, 1'b1);
         if (k == 0) chk1("drain_full1", full_1, 1'b0);
      end
      tick();
      chk1("drain_idle", valid_out, 1'b0);

      // Asynchronous reset with bytes queued discards them.
      reset = 1'b0;
      #1;
      reset = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         valid_in_0_c = 1'b1;
         data_in_0_c  = 8'(8'h11 * (k + 1));
         tick();
      end
      valid_in_0_c = 1'b0;
      chk1("q_full0", full_0, 1'b1);
      tick();
      chk8("q_data", data_out, 8'h11);
      chk1("q_valid", valid_out, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals("arst");
      tick();
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk1("post_rst_valid", valid_out, 1'b0);
         chk8("post_rst_data", data_out, 8'hBC);
      end
      chk2("post_rst_state", state_out, 2'd2);
      chk1("post_rst_full0", full_0, 1'b0);

      // Continuous traffic on both channels through SYNC and ACTIVE.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      for (int e = 2; e <= 28; e++) begin
         if (e <= 21) begin
            valid_in_0_c = 1'b1;
            valid_in_1_c = 1'b1;
            data_in_0_c  = 8'(8'h40 + e - 2);
            data_in_1_c  = 8'(8'h80 + e - 2);
         end else begin
            valid_in_0_c = 1'b0;
            valid_in_1_c = 1'b0;
         end
         tick();
         if (e == 5) begin
            chk1("str_full0", full_0, 1'b1);
            chk1("str_full1", full_1, 1'b1);
         end
         if (e == 21) begin
            chk4("str_drop0", drop_cnt_0, 4'd8);
            chk4("str_drop1", drop_cnt_1, 4'd9);
         end
         if (e >= 6) begin
            chk1("str_valid", valid_out, 1'b1);
            chk1("str_sel", sel_out, 1'(e % 2));
            if (e % 2 == 0) chk8("str_data0", data_out, exp0[(e - 6) / 2]);
            else chk8("str_data1", data_out, exp1[(e - 7) / 2]);
         end
      end
      tick();
      chk1("str_end_valid", valid_out, 1'b0);

      // Drop counters saturate at 15.
      valid_in_0_c = 1'b1; data_in_0_c = 8'h5A;
      valid_in_1_c = 1'b1; data_in_1_c = 8'hA5;
      for (int n = 1; n <= 24; n++) begin
         tick();
         if (n == 18) begin
            chk4("sat_drop0_18", drop_cnt_0, 4'd14);
            chk4("sat_drop1_18", drop_cnt_1, 4'd15);
         end
         if (n == 19) chk4("sat_drop0_19", drop_cnt_0, 4'd15);
      end
      chk4("sat_drop0", drop_cnt_0, 4'd15);
      chk4("sat_drop1", drop_cnt_1, 4'd15);
      valid_in_0_c = 1'b0;
      valid_in_1_c = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
